// File: rtl/spi_pwm_reg_config.sv
// SPI mode-0 write-only slave holding the PWM configuration registers.
// Pins are oversampled in clk; a write commits SYNC_STAGES+1 clk edges after ncs rises.
module spi_pwm_reg_config #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       txn_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;
  logic [SW-1:0]          settle_q;
  logic                   armed_q;

  state_t      state_q, state_nxt;
  logic [4:0]  cnt_q, cnt_nxt;
  logic [15:0] shreg_q, shreg_nxt;
  logic        wr_en;
  logic        done_nxt, err_nxt;
  logic        addr_ok;
  logic [7:0]  regs_q [5];

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-1-1:0], ncs};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  // The synchroniser comes out of reset holding ncs=1; if the pin is already
  // low that looks like a falling edge. Only accept frames once a real high
  // level on ncs has been seen after the chain has flushed its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != SETTLE) settle_q <= settle_q + 1'b1;
      if (settle_q == SETTLE && ncs_s) armed_q <= 1'b1;
    end
  end

  assign addr_ok = (int'(shreg_q[14:8]) < NUM_REGS);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shreg_nxt = shreg_q;
    wr_en     = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall && armed_q) begin
          state_nxt = SHIFT;
          cnt_nxt   = 5'd0;
          shreg_nxt = 16'h0000;
        end
      end
      SHIFT: begin
        // Frame end wins over a coincident sclk edge.
        if (ncs_rise) begin
          state_nxt = IDLE;
          if (cnt_q != 5'd16) begin
            err_nxt = 1'b1;
          end else if (shreg_q[15]) begin
            if (addr_ok) begin
              wr_en    = 1'b1;
              done_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end else if (sclk_rise) begin
          shreg_nxt = {shreg_q[14:0], copi_s};
          if (cnt_q != 5'd17) cnt_nxt = cnt_q + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      shreg_q  <= 16'h0000;
      txn_done <= 1'b0;
      txn_err  <= 1'b0;
      for (int k = 0; k < 5; k++) regs_q[k] <= 8'h00;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      shreg_q  <= shreg_nxt;
      txn_done <= done_nxt;
      txn_err  <= err_nxt;
      for (int k = 0; k < 5; k++) begin
        if (wr_en && shreg_q[14:8] == 7'(k)) regs_q[k] <= shreg_q[7:0];
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_pwm_reg_config.sv
// Bench for spi_pwm_reg_config: a frame model pushes expected commit/error
// events with register snapshots; a monitor pops them as the DUT pulses.
module tb_spi_pwm_reg_config;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       txn_done, txn_err;

  typedef struct packed {
    logic        is_err;
    logic [39:0] regs;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] mreg [5];
  int         n_cmp = 0;
  int         n_err = 0;

  spi_pwm_reg_config #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done), .txn_err(txn_err)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {mreg[4], mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  // Monitor: every pulse must match the next expected event.
  always @(posedge clk) begin
    #1;
    if (txn_done || txn_err) begin
      n_cmp++;
      if (txn_done && txn_err) begin
        n_err++;
        $display("FAIL both_pulses: done=%b err=%b, required exactly one", txn_done, txn_err);
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_pulse: done=%b err=%b, required no pulse", txn_done, txn_err);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (txn_err !== e.is_err || dut_regs() !== e.regs) begin
          n_err++;
          $display("FAIL event: err=%b regs=%h, required err=%b regs=%h",
                   txn_err, dut_regs(), e.is_err, e.regs);
        end
      end
    end
  end

  // Model of the frame decoder; pushes the event the DUT owes for this frame.
  task automatic expect_frame(input logic [31:0] data, input int nbits);
    ev_t e;
    logic [15:0] f;
    f = data[15:0];
    if (nbits != 16) begin
      e.is_err = 1'b1; e.regs = model_regs(); sb.push_back(e);
    end else if (f[15]) begin
      if (f[14:8] < 7'd5) begin
        mreg[f[10:8]] = f[7:0];
        e.is_err = 1'b0; e.regs = model_regs(); sb.push_back(e);
      end else begin
        e.is_err = 1'b1; e.regs = model_regs(); sb.push_back(e);
      end
    end
  endtask

  task automatic ncs_low();
    @(negedge clk); ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = data[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic ncs_high();
    repeat (4) @(negedge clk);
    ncs = 1'b1;
  endtask

  task automatic spi_frame(input logic [31:0] data, input int nbits);
    ncs_low();
    shift_bits(data, nbits);
    ncs_high();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 5; k++) mreg[k] = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut_regs() !== 40'h0 || txn_done !== 1'b0 || txn_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: regs=%h done=%b err=%b, required 0/0/0", dut_regs(), txn_done, txn_err);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (dut_regs() !== 40'h0) begin
      n_err++;
      $display("FAIL idle_after_reset: regs=%h, required 0", dut_regs());
    end
  endtask

  task automatic test_single_write();
    expect_frame(32'h80F0, 16);
    spi_frame(32'h80F0, 16);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (txn_done !== (c == 3) || en_reg_out_7_0 !== ((c == 3) ? 8'hF0 : 8'h00)) begin
        n_err++;
        $display("FAIL latency_edge%0d: done=%b reg0=%h, required done=%b reg0=%h",
                 c, txn_done, en_reg_out_7_0, (c == 3), (c == 3) ? 8'hF0 : 8'h00);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (txn_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_width: done=%b, required 0", txn_done);
    end
    drain();
    n_cmp++;
    if (sb.size() != 0 || dut_regs() !== 40'h00000000F0) begin
      n_err++;
      $display("FAIL single_write: pending=%0d regs=%h, required 0 / 00000000f0", sb.size(), dut_regs());
    end
  endtask

  task automatic test_two_writes();
    expect_frame(32'h8480, 16);
    spi_frame(32'h8480, 16);
    drain();
    expect_frame(32'h820F, 16);
    spi_frame(32'h820F, 16);
    drain();
    n_cmp++;
    if (sb.size() != 0 || dut_regs() !== model_regs() || pwm_duty_cycle !== 8'h80 || en_reg_pwm_7_0 !== 8'h0F) begin
      n_err++;
      $display("FAIL two_writes: pending=%0d regs=%h, required 0 / %h", sb.size(), dut_regs(), model_regs());
    end
  endtask

  task automatic test_malformed();
    int n [2];
    n[0] = 15;
    n[1] = 17;
    for (int t = 0; t < 2; t++) begin
      expect_frame(32'h1A55A, n[t]);
      spi_frame(32'h1A55A, n[t]);
      drain();
      n_cmp++;
      if (sb.size() != 0 || dut_regs() !== model_regs()) begin
        n_err++;
        $display("FAIL malformed_%0dbit: pending=%0d regs=%h, required 0 / %h",
                 n[t], sb.size(), dut_regs(), model_regs());
      end
    end
  endtask

  task automatic test_invalid_and_read();
    expect_frame(32'h8555, 16);
    spi_frame(32'h8555, 16);
    drain();
    n_cmp++;
    if (sb.size() != 0 || dut_regs() !== model_regs()) begin
      n_err++;
      $display("FAIL invalid_addr: pending=%0d regs=%h, required 0 / %h", sb.size(), dut_regs(), model_regs());
    end
    expect_frame(32'h01AA, 16);
    spi_frame(32'h01AA, 16);
    drain();
    n_cmp++;
    if (en_reg_out_15_8 !== 8'h00 || dut_regs() !== model_regs()) begin
      n_err++;
      $display("FAIL read_frame: regs=%h, required %h", dut_regs(), model_regs());
    end
  endtask

  task automatic test_reset_recovery();
    ncs_low();
    shift_bits(32'h83, 8);
    @(negedge clk); rst_n = 1'b0;
    for (int k = 0; k < 5; k++) mreg[k] = 8'h00;
    #1;
    n_cmp++;
    if (dut_regs() !== 40'h0 || txn_done !== 1'b0 || txn_err !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reset: regs=%h done=%b err=%b, required 0/0/0", dut_regs(), txn_done, txn_err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    shift_bits(32'h3C, 8);
    ncs_high();
    drain();
    n_cmp++;
    if (dut_regs() !== 40'h0) begin
      n_err++;
      $display("FAIL remainder_ignored: regs=%h, required 0", dut_regs());
    end
    expect_frame(32'h833C, 16);
    spi_frame(32'h833C, 16);
    drain();
    n_cmp++;
    if (sb.size() != 0 || en_reg_pwm_15_8 !== 8'h3C || dut_regs() !== model_regs()) begin
      n_err++;
      $display("FAIL recovery_write: pending=%0d regs=%h, required 0 / %h", sb.size(), dut_regs(), model_regs());
    end
  endtask

  task automatic test_back_to_back();
    expect_frame(32'h8111, 16);
    expect_frame(32'h8122, 16);
    spi_frame(32'h8111, 16);
    @(negedge clk);
    spi_frame(32'h8122, 16);
    drain();
    n_cmp++;
    if (sb.size() != 0 || en_reg_out_15_8 !== 8'h22 || dut_regs() !== model_regs()) begin
      n_err++;
      $display("FAIL back_to_back: pending=%0d regs=%h, required 0 / %h", sb.size(), dut_regs(), model_regs());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_two_writes();
    test_malformed();
    test_invalid_and_read();
    test_reset_recovery();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
